spi_link: RTL and testbench
===========================

Name: spi_link

Overview:
- Single-clock SPI subsystem with two engines: a mode-0 SPI master and a matching SPI slave, wired together internally over CS/SCLK/MOSI/MISO.
- Performs one full-duplex 8-bit exchange per start pulse.
- The master's byte lands in the slave, and the slave's byte lands in the master.
- The bus pins are also brought out as outputs for observation and debug. The block is used as a link/loopback unit and as the reference implementation of the team's SPI timing.

Parameters:
DATA_W, 8, transfer width in bits; MSB first.
CLK_DIV, 2, clk cycles per SCLK half-period; legal values are 2 or more.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous active-low reset.
start  input  1  transfer request; sampled only while idle.
master_data_in  input  DATA_W  byte the master transmits; latched on the accepted start.
slave_data_in  input  DATA_W  byte the slave transmits; latched when CS falls.
master_data_out  output  DATA_W  byte received by the master.
slave_data_out  output  DATA_W  byte received by the slave.
done  output  1  one-cycle pulse at transfer end.
busy  output  1  high while a transfer is in progress.
cs  output  1  chip select, active low.
sclk  output  1  serial clock, idle low.
mosi  output  1  master-out serial data.
miso  output  1  slave-out serial data.

Behaviour:

Reset (rst=0 at a clock edge):
- cs=1, sclk=0, mosi=0, miso=0, done=0, busy=0.
- master_data_out=0 and slave_data_out=0.
- All shift registers and counters cleared.
- Reset mid-transfer aborts the transfer immediately: no done pulse, and the outputs hold the reset values.

Master states are IDLE, XFER and FINISH.

IDLE:
- cs=1, sclk=0.
- If start=1 at an edge, latch master_data_in into the TX shifter and go to XFER. At that same edge: cs←0, busy←1, mosi←TX MSB.
- start=0 stays in IDLE.

XFER:
- A half-period counter toggles sclk every CLK_DIV cycles. The first rise comes CLK_DIV cycles after cs falls.
- On the edge where sclk is driven 0→1: shift miso into the RX shifter (MSB first).
- On the edge where sclk is driven 1→0: advance mosi to the next TX bit.
- After the DATA_W-th falling edge, go to FINISH.

FINISH (one cycle):
- cs←1, sclk=0, mosi←0, busy←0, done←1 for exactly one cycle.
- master_data_out←RX shifter.
- Return to IDLE.
- start is sampled again from the next edge.

Transfer timing:
- cs is low for 2·DATA_W·CLK_DIV cycles; this is 32 cycles at the defaults.
- done asserts the cycle cs returns high.
- start asserted while busy is ignored; it is neither queued nor restarts the transfer.

Slave:
- Clocked by clk; it edge-detects the registered cs and sclk using one-cycle-delayed copies.
- cs falling detected: latch slave_data_in into the slave TX shifter, set miso←MSB, clear the bit counter.
- sclk rising detected with cs=0: shift mosi into the slave RX shifter and increment the bit counter. When the counter reaches DATA_W, slave_data_out←received byte. This completes before done asserts.
- sclk falling detected with cs=0: miso←next TX bit.
- cs high: miso=0. A partial transfer (cs rising before DATA_W bits) does not update slave_data_out.
- Timing margin: the slave reacts one cycle after each bus edge. CLK_DIV≥2 guarantees miso is stable before the master's sampling edge and mosi is stable at the slave's sample.

Data rules:
- Bit order is MSB first on both directions.
- Outputs hold their last value until the next completed transfer.

Test Plan:
- Basic exchange: reset 2 cycles, master_data_in=0xAA, slave_data_in=0xCC, 1-cycle start → done pulses once exactly 32 cycles after cs falls; master_data_out=0xCC, slave_data_out=0xAA; cs=1, busy=0 afterwards.
- Bus waveform: same transfer → 8 sclk pulses, each high for 2 cycles; mosi sequence 1,0,1,0,1,0,1,0 stable across every sclk rise; miso sequence 1,1,0,0,1,1,0,0.
- Back-to-back transfers: 0xFF/0x00, then 0x00/0xFF, then 0x5A/0xA5 → each result is swapped correctly; every value is updated only at its own done.
- start held high 10 cycles during a transfer → only one transfer and one done pulse; a new transfer starts only if start is still high in IDLE.
- Reset mid-transfer: rst=0 after the 3rd sclk rise → cs=1, sclk=0, no done, both data_out=0. The next transfer with 0x3C/0xC3 completes correctly.
- CLK_DIV=4 instance with 0x81/0x7E → cs low for 64 cycles; data is swapped correctly.

Source files
------------

// File: rtl/spi_link.sv
// ============================================================================
// Module   : spi_link
// Purpose  : Mode-0 SPI master and slave joined internally; full-duplex byte swap
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_link #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] master_data_in,
    input  logic [DATA_W-1:0] slave_data_in,
    output logic [DATA_W-1:0] master_data_out,
    output logic [DATA_W-1:0] slave_data_out,
    output logic              done,
    output logic              busy,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    output logic              miso
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] c_DIV_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_DIV_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] c_BIT_ONE  = BIT_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_XFER   = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;

    // Master registers
    logic [1:0]        r_state,    w_state_nxt;
    logic [CNT_W-1:0]  r_div_cnt,  w_div_nxt;
    logic [BIT_W-1:0]  r_fall_cnt, w_fall_nxt;
    logic [DATA_W-1:0] r_tx,       w_tx_nxt;
    logic [DATA_W-1:0] r_rx,       w_rx_nxt;
    logic [DATA_W-1:0] r_mdata,    w_mdata_nxt;
    logic              r_cs,       w_cs_nxt;
    logic              r_sclk,     w_sclk_nxt;
    logic              r_mosi,     w_mosi_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;

    // Slave registers
    logic              r_cs_d;
    logic              r_sclk_d;
    logic [DATA_W-1:0] r_stx;
    logic [DATA_W-1:0] r_srx;
    logic [DATA_W-1:0] r_sdata;
    logic [BIT_W-1:0]  r_sbit;
    logic              r_miso;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_div_cnt  <= '0;
            r_fall_cnt <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_mdata    <= '0;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_nxt;
            r_fall_cnt <= w_fall_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_mdata    <= w_mdata_nxt;
            r_cs       <= w_cs_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_fall_nxt  = r_fall_cnt;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_mdata_nxt = r_mdata;
        w_cs_nxt    = r_cs;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_cs_nxt   = 1'b1;
                w_sclk_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = c_XFER;
                    w_tx_nxt    = master_data_in;
                    w_rx_nxt    = '0;
                    w_div_nxt   = '0;
                    w_fall_nxt  = '0;
                    w_cs_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_mosi_nxt  = master_data_in[DATA_W-1];
                end
            end
            c_XFER: begin
                if (r_div_cnt == c_DIV_MAX) begin
                    w_div_nxt  = '0;
                    w_sclk_nxt = ~r_sclk;
                    if (!r_sclk) begin
                        w_rx_nxt = {r_rx[DATA_W-2:0], r_miso};
                    end else begin
                        w_fall_nxt = r_fall_cnt + c_BIT_ONE;
                        w_tx_nxt   = r_tx << 1;
                        w_mosi_nxt = r_tx[DATA_W-2];
                        // Last falling edge closes the frame in the same cycle so cs stays low 2*DATA_W*CLK_DIV cycles
                        if (r_fall_cnt == c_LAST_BIT) begin
                            w_state_nxt = c_FINISH;
                            w_cs_nxt    = 1'b1;
                            w_mosi_nxt  = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_mdata_nxt = r_rx;
                        end
                    end
                end else begin
                    w_div_nxt = r_div_cnt + c_DIV_ONE;
                end
            end
            c_FINISH: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Slave works one cycle behind the bus using delayed copies of cs/sclk
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cs_d   <= 1'b1;
            r_sclk_d <= 1'b0;
            r_stx    <= '0;
            r_srx    <= '0;
            r_sdata  <= '0;
            r_sbit   <= '0;
            r_miso   <= 1'b0;
        end else begin
            r_cs_d   <= r_cs;
            r_sclk_d <= r_sclk;
            if (r_cs) begin
                r_miso <= 1'b0;
            end else if (r_cs_d) begin
                r_stx  <= slave_data_in;
                r_miso <= slave_data_in[DATA_W-1];
                r_sbit <= '0;
            end else if (r_sclk && !r_sclk_d) begin
                r_srx  <= {r_srx[DATA_W-2:0], r_mosi};
                r_sbit <= r_sbit + c_BIT_ONE;
                if (r_sbit == c_LAST_BIT) begin
                    r_sdata <= {r_srx[DATA_W-2:0], r_mosi};
                end
            end else if (!r_sclk && r_sclk_d) begin
                r_stx  <= r_stx << 1;
                r_miso <= r_stx[DATA_W-2];
            end
        end
    end

    assign master_data_out = r_mdata;
    assign slave_data_out  = r_sdata;
    assign done            = r_done;
    assign busy            = r_busy;
    assign cs              = r_cs;
    assign sclk            = r_sclk;
    assign mosi            = r_mosi;
    assign miso            = r_miso;

endmodule

`default_nettype wire

// File: tb/tb_spi_link.sv
// ============================================================================
// Module   : tb_spi_link
// Purpose  : Directed and random byte exchanges on spi_link, CLK_DIV 2 and 4
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_link;

    localparam int c_DW   = 8;
    localparam int c_DIVA = 2;
    localparam int c_DIVB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       r_start_a = 1'b0, r_start_b = 1'b0;
    logic [7:0] r_m_in_a = '0, r_s_in_a = '0, r_m_in_b = '0, r_s_in_b = '0;
    logic [7:0] w_m_out_a, w_s_out_a, w_m_out_b, w_s_out_b;
    logic       w_done_a, w_busy_a, w_cs_a, w_sclk_a, w_mosi_a, w_miso_a;
    logic       w_done_b, w_busy_b, w_cs_b, w_sclk_b, w_mosi_b, w_miso_b;

    int n_checks = 0;
    int n_errors = 0;

    // Per-transfer observations gathered by drive_watch
    int         st_done, st_csfall, st_lat, st_cslow, st_rises;
    int         st_hi_min, st_hi_max, st_unstable, st_early;
    logic [7:0] st_mosi_bits, st_miso_bits;

    always #5 clk = ~clk;

    spi_link #(.DATA_W(c_DW), .CLK_DIV(c_DIVA)) u_dut_a (
        .clk(clk), .rst(rst), .start(r_start_a),
        .master_data_in(r_m_in_a), .slave_data_in(r_s_in_a),
        .master_data_out(w_m_out_a), .slave_data_out(w_s_out_a),
        .done(w_done_a), .busy(w_busy_a), .cs(w_cs_a), .sclk(w_sclk_a),
        .mosi(w_mosi_a), .miso(w_miso_a)
    );

    spi_link #(.DATA_W(c_DW), .CLK_DIV(c_DIVB)) u_dut_b (
        .clk(clk), .rst(rst), .start(r_start_b),
        .master_data_in(r_m_in_b), .slave_data_in(r_s_in_b),
        .master_data_out(w_m_out_b), .slave_data_out(w_s_out_b),
        .done(w_done_b), .busy(w_busy_b), .cs(w_cs_b), .sclk(w_sclk_b),
        .mosi(w_mosi_b), .miso(w_miso_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise start on instance A for 'hold' cycles and observe 'watch' cycles
    task automatic drive_watch(input logic [7:0] m, input logic [7:0] s,
                               input int hold, input int watch);
        logic       prev_sclk, prev_mosi, prev_cs;
        logic [7:0] mout0, sout0;
        int         hi_run, first_low;
        st_done = 0; st_csfall = 0; st_lat = -1; st_cslow = 0; st_rises = 0;
        st_hi_min = 999; st_hi_max = 0; st_unstable = 0; st_early = 0;
        st_mosi_bits = '0; st_miso_bits = '0;
        first_low = -1; hi_run = 0;
        mout0 = w_m_out_a; sout0 = w_s_out_a;
        prev_sclk = w_sclk_a; prev_mosi = w_mosi_a; prev_cs = w_cs_a;
        r_m_in_a = m; r_s_in_a = s; r_start_a = 1'b1;
        for (int i = 0; i < watch; i++) begin
            if (i == hold) r_start_a = 1'b0;
            @(negedge clk);
            if (prev_cs && !w_cs_a) begin
                st_csfall++;
                if (first_low < 0) first_low = i;
            end
            if (st_done == 0 && !w_cs_a) st_cslow++;
            if (w_done_a) begin
                if (st_done == 0) st_lat = i - first_low;
                st_done++;
            end
            if (st_done == 0) begin
                if (w_sclk_a && !prev_sclk) begin
                    st_rises++;
                    st_mosi_bits = {st_mosi_bits[6:0], w_mosi_a};
                    st_miso_bits = {st_miso_bits[6:0], w_miso_a};
                    if (w_mosi_a !== prev_mosi) st_unstable++;
                end
                if (w_sclk_a) hi_run++;
                else if (prev_sclk) begin
                    if (hi_run < st_hi_min) st_hi_min = hi_run;
                    if (hi_run > st_hi_max) st_hi_max = hi_run;
                    hi_run = 0;
                end
                if (w_m_out_a !== mout0) st_early++;
                if (first_low >= 0 && (i - first_low) < 2 * c_DW * c_DIVA - 1 && w_s_out_a !== sout0)
                    st_early++;
            end
            prev_sclk = w_sclk_a; prev_mosi = w_mosi_a; prev_cs = w_cs_a;
        end
        r_start_a = 1'b0;
    endtask

    // Single transfer on instance B; returns cs-low cycle count and done count
    task automatic xfer_b(input logic [7:0] m, input logic [7:0] s, input string tag);
        int cslow, dones;
        cslow = 0; dones = 0;
        r_m_in_b = m; r_s_in_b = s; r_start_b = 1'b1;
        @(negedge clk);
        r_start_b = 1'b0;
        for (int i = 0; i < 300 && dones == 0; i++) begin
            if (!w_cs_b) cslow++;
            if (w_done_b) dones++;
            @(negedge clk);
        end
        check({tag, "_cslow"}, cslow, 2 * c_DW * c_DIVB);
        check({tag, "_done"}, dones, 1);
        check({tag, "_mout"}, w_m_out_b, s);
        check({tag, "_sout"}, w_s_out_b, m);
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] tbl_m [3] = '{8'hFF, 8'h00, 8'h5A};
    logic [7:0] tbl_s [3] = '{8'h00, 8'hFF, 8'hA5};

    initial begin
        logic [7:0] rm, rs;
        int         rises, dones;
        logic       prev;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cs",   w_cs_a, 1'b1);
        check("rst_bus",  {w_sclk_a, w_mosi_a, w_miso_a, w_done_a, w_busy_a}, 5'b0);
        check("rst_outs", {w_m_out_a, w_s_out_a}, 16'h0);
        check("rst_cs_b", w_cs_b, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        // Basic exchange and bus waveform
        drive_watch(8'hAA, 8'hCC, 1, 40);
        check("basic_done",  st_done, 1);
        check("basic_lat",   st_lat, 2 * c_DW * c_DIVA);
        check("basic_cslow", st_cslow, 2 * c_DW * c_DIVA);
        check("basic_mout",  w_m_out_a, 8'hCC);
        check("basic_sout",  w_s_out_a, 8'hAA);
        check("basic_idle",  {w_cs_a, w_busy_a}, 2'b10);
        check("wave_rises",  st_rises, c_DW);
        check("wave_mosi",   st_mosi_bits, 8'hAA);
        check("wave_miso",   st_miso_bits, 8'hCC);
        check("wave_hi_min", st_hi_min, c_DIVA);
        check("wave_hi_max", st_hi_max, c_DIVA);
        check("wave_stable", st_unstable, 0);
        check("basic_early", st_early, 0);

        // Back-to-back directed transfers
        for (int k = 0; k < 3; k++) begin
            drive_watch(tbl_m[k], tbl_s[k], 1, 36);
            check("b2b_done",  st_done, 1);
            check("b2b_mout",  w_m_out_a, tbl_s[k]);
            check("b2b_sout",  w_s_out_a, tbl_m[k]);
            check("b2b_early", st_early, 0);
        end

        // Random transfers against the swap model
        for (int k = 0; k < 6; k++) begin
            rm = 8'($urandom);
            rs = 8'($urandom);
            drive_watch(rm, rs, 1, 36);
            check("rnd_done",  st_done, 1);
            check("rnd_lat",   st_lat, 2 * c_DW * c_DIVA);
            check("rnd_mout",  w_m_out_a, rs);
            check("rnd_sout",  w_s_out_a, rm);
            check("rnd_mosi",  st_mosi_bits, rm);
            check("rnd_miso",  st_miso_bits, rs);
        end

        // start held during a transfer is ignored
        drive_watch(8'h96, 8'h69, 10, 60);
        check("hold10_done",   st_done, 1);
        check("hold10_csfall", st_csfall, 1);
        check("hold10_mout",   w_m_out_a, 8'h69);
        check("hold10_sout",   w_s_out_a, 8'h96);

        // start still high back in idle launches a second transfer
        drive_watch(8'h12, 8'h34, 40, 100);
        check("hold40_done",   st_done, 2);
        check("hold40_csfall", st_csfall, 2);
        check("hold40_mout",   w_m_out_a, 8'h34);

        // Reset after the 3rd sclk rise
        r_m_in_a = 8'hE7; r_s_in_a = 8'h18; r_start_a = 1'b1;
        @(negedge clk);
        r_start_a = 1'b0;
        rises = 0; prev = w_sclk_a;
        for (int i = 0; i < 40 && rises < 3; i++) begin
            @(negedge clk);
            if (w_sclk_a && !prev) rises++;
            prev = w_sclk_a;
        end
        check("mid_rises", rises, 3);
        rst = 1'b0;
        @(negedge clk);
        check("mid_bus",  {w_cs_a, w_sclk_a, w_done_a, w_busy_a}, 4'b1000);
        check("mid_outs", {w_m_out_a, w_s_out_a}, 16'h0);
        rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w_done_a) dones++;
        end
        check("mid_nodone", dones, 0);
        check("mid_hold",   {w_m_out_a, w_s_out_a}, 16'h0);

        drive_watch(8'h3C, 8'hC3, 1, 40);
        check("post_done", st_done, 1);
        check("post_mout", w_m_out_a, 8'hC3);
        check("post_sout", w_s_out_a, 8'h3C);

        // Slower bus instance
        xfer_b(8'h81, 8'h7E, "div4");
        rm = 8'($urandom);
        rs = 8'($urandom);
        xfer_b(rm, rs, "div4_rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
